uart_rx_os: RTL and testbench
=============================

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 8: number of tick pulses per UART bit period; legal values are even numbers of 4 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame (frame = 1 start, DATA_BITS data, 1 stop, no parity).
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tick, input, 1 bit: one-clk-wide oversample strobe at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rx, input, 1 bit: serial line; idle high; assumed already synchronous to clk.
REQ-007 SHALL have port rx_data, output, DATA_BITS bits: last correctly framed byte, LSB received first.
REQ-008 SHALL have port rx_done, output, 1 bit: one-clk pulse when rx_data updates.
REQ-009 SHALL have port frame_err, output, 1 bit: one-clk pulse when the stop bit is sampled low.
REQ-010 SHALL have port rx_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP; the tick counter and state advance only in cycles where tick=1; with tick=0 all state holds.
REQ-012 IDLE: tick with rx=0 -> START, tick counter cleared to 0; otherwise remain in IDLE.
REQ-013 START: counter increments per tick; at count OVERSAMPLE/2-1, rx=0 -> DATA with counter and bit index cleared; rx=1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: counter counts 0..OVERSAMPLE-1 and wraps to 0; at count OVERSAMPLE-1 the bit value shifts into the shift register, LSB first, and the bit index increments.
REQ-015 DATA: after bit index DATA_BITS-1 is sampled -> STOP with counter cleared.
REQ-016 STOP: at count OVERSAMPLE-1, a sampled bit of 1 loads rx_data from the shift register and pulses rx_done; a sampled 0 pulses frame_err and leaves rx_data unchanged; both cases -> IDLE in the same cycle.
REQ-017 rx_done and frame_err SHALL be registered, SHALL be high for exactly one clk in the cycle after the sampling edge, and SHALL never be high together.
REQ-018 Return to IDLE at mid-stop-bit SHALL allow a start bit that immediately follows the stop bit to be detected, so back-to-back frames are received without loss.
REQ-019 Bit counter width SHALL be ceil(log2(DATA_BITS+1)); tick counter width SHALL be ceil(log2(OVERSAMPLE)); no counter SHALL exceed its terminal value.

Reset
REQ-020 While rst=0: state=IDLE, counters=0, shift register=0, rx_data=0, rx_done=0, frame_err=0, rx_busy=0, taking effect immediately without clk.
REQ-021 Reset asserted mid-frame SHALL abandon the frame with no rx_done or frame_err pulse; after release, the next falling edge on rx starts a new frame.

Configuration
REQ-022 Macro UART_RX_MAJORITY_EN defined: each data and stop bit value SHALL be the 2-of-3 majority of rx sampled on ticks at counts OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1, decided at OVERSAMPLE-1.
REQ-023 Macro UART_RX_MAJORITY_EN undefined: bit value SHALL be the single rx sample at count OVERSAMPLE-1; no vote registers SHALL be synthesized.
REQ-024 Start-bit validation (REQ-013) SHALL be a single sample in both builds; latency of rx_done SHALL be identical in both builds.

Verification (OVERSAMPLE=8, DATA_BITS=8, tick every 10 clk, bit period 80 clk)
REQ-025 Send frame with byte 8'hA5 and stop=1 -> exactly one rx_done pulse, rx_data=8'hA5, frame_err never high, rx_busy low after the pulse.
REQ-026 Send 8'h3C then 8'hC3 back-to-back (no idle gap) -> two rx_done pulses, rx_data 8'h3C then 8'hC3.
REQ-027 Send 8'h5A with stop=0 after prior 8'hA5 -> one frame_err pulse, no rx_done, rx_data stays 8'hA5.
REQ-028 rx low for 2 ticks then high -> state returns to IDLE, no rx_done or frame_err pulse, rx_busy high only during the glitch.
REQ-029 Assert rst during data bit 4 of 8'hFF -> all outputs 0 immediately and no pulse; then 8'h81 -> rx_data=8'h81.
REQ-030 Send 8'h00 with rx forced to 1 for the single tick at count 6 of bit 2 -> with UART_RX_MAJORITY_EN rx_data=8'h00; without it rx_data=8'h00 as well (count 6 is not the sampling point); forced at count 7 instead -> with macro 8'h00, without macro 8'h04.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop, no parity.
// Define UART_RX_MAJORITY_EN to take data/stop bits as a 2-of-3 vote of the last three ticks.
module uart_rx_os #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 0) ? $clog2(DATA_BITS + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 bit_val;
  logic [DATA_BITS:0]   sh_ext;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_V0 = CW'(OVERSAMPLE - 3);
  localparam logic [CW-1:0] CNT_V1 = CW'(OVERSAMPLE - 2);

  logic [1:0] vote_q, vote_d;

  // the third vote is the live rx sample at the decision tick
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx) | (vote_q[1] & rx);

  always_comb begin
    vote_d = vote_q;
    if (tick && (state_q == DATA || state_q == STOP)) begin
      if (cnt_q == CNT_V0) vote_d[0] = rx;
      if (cnt_q == CNT_V1) vote_d[1] = rx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vote_q <= '0;
    else      vote_q <= vote_d;
  end
`else
  assign bit_val = rx;
`endif

  assign sh_ext = {bit_val, sh_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          // single mid-start sample rejects short glitches
          if (cnt_q == CNT_MID) begin
            if (!rx) begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sh_d  = sh_ext[DATA_BITS:1];
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          // leaving at mid-stop keeps half a bit of margin for a following start edge
          if (cnt_q == CNT_LAST) begin
            if (bit_val) begin
              data_d = sh_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: OVERSAMPLE=8, DATA_BITS=8, tick every 10 clk.
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, frame_err, rx_busy;

  int nchk = 0;
  int nfail = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx_os #(.OVERSAMPLE(8), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      got_q.push_back(rx_data);
    end
    if (frame_err) ferr_cnt++;
    if (rx_done && frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_tick();
    repeat (9) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // one bit period; force_t selects a tick index (0..7) in this bit driven as 1
  task automatic drive_bit(input logic b, input int force_t);
    for (int t = 0; t < 8; t++) begin
      rx = (t == force_t) ? 1'b1 : b;
      do_tick();
    end
    rx = 1'b1;
  endtask

  // force_bit/force_t inject a single high tick into one data bit
  task automatic send_frame(input logic [7:0] d, input logic stop, input int force_bit, input int force_t);
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == force_bit) ? force_t : -1);
    drive_bit(stop, -1);
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    repeat (n) do_tick();
  endtask

  task automatic clr();
    done_cnt = 0;
    ferr_cnt = 0;
    got_q.delete();
  endtask

  logic [7:0] exp_force7;

  initial begin
`ifdef UART_RX_MAJORITY_EN
    exp_force7 = 8'h00;
`else
    exp_force7 = 8'h04;
`endif
    #1;
    chk("rst_data", rx_data, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", rx_busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_ticks(3);

    clr();
    send_frame(8'hA5, 1'b1, -1, -1);
    chk("a5_done_cnt", done_cnt, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr_cnt", ferr_cnt, 0);
    chk("a5_busy_after", rx_busy, 0);
    idle_ticks(2);

    clr();
    send_frame(8'h3C, 1'b1, -1, -1);
    send_frame(8'hC3, 1'b1, -1, -1);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_first", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h3C);
    chk("b2b_second", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'hC3);
    chk("b2b_ferr_cnt", ferr_cnt, 0);
    idle_ticks(2);

    send_frame(8'hA5, 1'b1, -1, -1);
    idle_ticks(2);
    clr();
    send_frame(8'h5A, 1'b0, -1, -1);
    idle_ticks(2);
    chk("ferr_cnt", ferr_cnt, 1);
    chk("ferr_done_cnt", done_cnt, 0);
    chk("ferr_data_kept", rx_data, 8'hA5);

    clr();
    rx = 1'b0;
    do_tick();
    chk("glitch_busy", rx_busy, 1);
    do_tick();
    idle_ticks(4);
    chk("glitch_idle", rx_busy, 0);
    idle_ticks(4);
    chk("glitch_done_cnt", done_cnt, 0);
    chk("glitch_ferr_cnt", ferr_cnt, 0);

    clr();
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
    rx = 1'b1;
    do_tick();
    do_tick();
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_done", rx_done, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_busy", rx_busy, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle_ticks(6);
    chk("mid_rst_no_pulse", done_cnt + ferr_cnt, 0);
    send_frame(8'h81, 1'b1, -1, -1);
    chk("post_rst_data", rx_data, 8'h81);
    chk("post_rst_done_cnt", done_cnt, 1);
    idle_ticks(2);

    // tick index t in a data bit sees counter value (t+3)%8
    send_frame(8'h00, 1'b1, 2, 3);
    chk("force_cnt6", rx_data, 8'h00);
    idle_ticks(2);
    send_frame(8'hFF, 1'b1, -1, -1);
    idle_ticks(2);
    send_frame(8'h00, 1'b1, 2, 4);
    chk("force_cnt7", rx_data, exp_force7);
    idle_ticks(2);

    chk("never_both", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
